// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine and CPU/external-bus arbiter.
// The CPU keeps IO/HRAM access while a copy owns the external bus.
module oam_dma_ctrl #(
  parameter int OAM_LEN     = 160,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_rd,
  output logic        io_wr,
  input  logic [7:0]  io_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        dma_active
);

  typedef enum logic [1:0] {
    IDLE, START, ACTIVE, DRAIN
  } state_t;

  typedef enum logic [2:0] {
    SRC_NONE, SRC_MEM, SRC_IO, SRC_REG, SRC_BLK
  } rsrc_t;

  localparam logic [7:0] LAST = 8'(OAM_LEN - 1);
  localparam logic [7:0] DLY0 = 8'(START_DELAY - 1);

  state_t     state;
  rsrc_t      rsrc;
  logic [7:0] src_page;
  logic [7:0] idx;
  logic [7:0] idx_prev;
  logic [7:0] dly;
  logic       rd_pend;

  logic is_reg;
  logic is_io;
  logic is_mem;
  logic bus_free;
  logic cpu_acc;

  assign is_reg   = cpu_addr == 16'hFF46;
  assign is_mem   = ~&cpu_addr[15:8];
  assign is_io    = !is_mem && !is_reg;
  assign bus_free = state == IDLE || state == START;
  assign cpu_acc  = cpu_rd || cpu_wr;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    unique case (1'b1)
      state == ACTIVE: begin
        mem_addr = {src_page, idx};
        mem_rd   = 1'b1;
      end
      bus_free && is_mem && cpu_acc: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wr ? cpu_wdata : 8'h00;
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
      end
      default: ;
    endcase
  end

  assign io_addr  = (is_io && cpu_acc) ? cpu_addr[7:0] : 8'h00;
  assign io_wdata = (is_io && cpu_wr) ? cpu_wdata : 8'h00;
  assign io_rd    = is_io && cpu_rd;
  assign io_wr    = is_io && cpu_wr;

  // Data returns one cycle after the DMA read that fetched it.
  assign oam_we    = rd_pend;
  assign oam_addr  = rd_pend ? idx_prev : 8'h00;
  assign oam_wdata = rd_pend ? mem_rdata : 8'h00;

  assign dma_active = state != IDLE;

  always_comb begin
    cpu_rdata = 8'h00;
    unique case (rsrc)
      SRC_MEM: cpu_rdata = mem_rdata;
      SRC_IO:  cpu_rdata = io_rdata;
      SRC_REG: cpu_rdata = src_page;
      SRC_BLK: cpu_rdata = 8'hFF;
      default: cpu_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rsrc     <= SRC_NONE;
      src_page <= 8'h00;
      idx      <= 8'h00;
      idx_prev <= 8'h00;
      dly      <= 8'h00;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= state == ACTIVE;
      if (state == ACTIVE) idx_prev <= idx;

      rsrc <= SRC_NONE;
      if (cpu_rd) begin
        if (is_reg)        rsrc <= SRC_REG;
        else if (is_io)    rsrc <= SRC_IO;
        else if (bus_free) rsrc <= SRC_MEM;
        else               rsrc <= SRC_BLK;
      end

      unique case (state)
        IDLE: ;
        START: begin
          if (dly == 8'h00) state <= ACTIVE;
          else              dly   <= dly - 8'h01;
        end
        ACTIVE: begin
          if (idx == LAST) state <= DRAIN;
          else             idx   <= idx + 8'h01;
        end
        DRAIN: state <= IDLE;
        default: state <= IDLE;
      endcase

      // A page write restarts from any state; it wins over the FSM step.
      if (cpu_wr && is_reg) begin
        src_page <= cpu_wdata;
        idx      <= 8'h00;
        dly      <= DLY0;
        state    <= START;
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed/randomized bench for oam_dma_ctrl.
// Models the external memory, IO space and the resulting OAM image.
module tb_oam_dma_ctrl;

  localparam int OAM_LEN = 160;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_rd;
  logic        io_wr;
  logic [7:0]  io_rdata = '0;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        dma_active;

  oam_dma_ctrl #(.OAM_LEN(OAM_LEN), .START_DELAY(1)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rd(io_rd), .io_wr(io_wr), .io_rdata(io_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [65536];
  logic [7:0] io [256];
  logic [7:0] oam_m [256];
  int cyc = 0;
  int act_cnt = 0;
  int we_q[$];
  int rd_q[$];

  int vectors = 0;
  int miscompares = 0;
  int tx_t = 0;
  bit tx_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (io_rd)  io_rdata  <= io[io_addr];
  end

  // A DMA read is any mem_rd that is not the CPU's own forwarded read.
  always @(negedge clk) begin
    if (oam_we) begin
      oam_m[oam_addr] <= oam_wdata;
      we_q.push_back(cyc);
    end
    if (mem_rd && !(cpu_rd && cpu_addr == mem_addr)) rd_q.push_back(cyc);
    if (dma_active) act_cnt <= act_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr46(input logic [7:0] page);
    cpu_addr  = 16'hFF46;
    cpu_wdata = page;
    cpu_wr    = 1'b1;
    tx_t      = cyc;
    tx_on     = 1'b1;
    mid();
    tick();
    cpu_wr    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
  endtask

  task automatic cpu_acc(input bit rd, input logic [15:0] a,
                         input logic [7:0] d);
    bit busy;
    bit io_hit;
    logic [7:0] exp_d;
    busy   = tx_on && cyc >= tx_t + 2 && cyc <= tx_t + 2 + OAM_LEN;
    io_hit = a >= 16'hFF00;
    cpu_addr  = a;
    cpu_rd    = rd;
    cpu_wr    = !rd;
    cpu_wdata = d;
    mid();
    chk("mem_wr", 32'(mem_wr), 32'(!io_hit && !busy && !rd));
    if (io_hit) begin
      chk("io_rd", 32'(io_rd), 32'(rd));
      chk("io_wr", 32'(io_wr), 32'(!rd));
      chk("io_addr", 32'(io_addr), 32'(a[7:0]));
      if (!rd) chk("io_wdata", 32'(io_wdata), 32'(d));
    end else begin
      chk("io_strobe", 32'(io_rd | io_wr), 32'd0);
      if (!busy) begin
        chk("mem_rd_fwd", 32'(mem_rd), 32'(rd));
        chk("mem_addr_fwd", 32'(mem_addr), 32'(a));
      end
    end
    exp_d = io_hit ? io[a[7:0]] : (busy ? 8'hFF : mem[a]);
    tick();
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    mid();
    if (rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_d));
    tick();
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      mid();
      if (!dma_active) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk("idle_timeout", 32'(done), 32'd1);
    tick();
    tx_on = 1'b0;
  endtask

  task automatic chk_oam(input logic [7:0] page);
    for (int i = 0; i < OAM_LEN; i++)
      chk("oam_byte", 32'(oam_m[i]), 32'(mem[{page, 8'(i)}]));
  endtask

  initial begin
    int w0;
    int r0;
    int a0;
    int t;
    logic [15:0] a;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) io[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) oam_m[i] = 8'h00;
    for (int i = 0; i < OAM_LEN; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;

    tick();
    tick();
    mid();
    chk("rst_active", 32'(dma_active), 32'd0);
    chk("rst_oam_we", 32'(oam_we), 32'd0);
    chk("rst_strobes", 32'({mem_rd, mem_wr, io_rd, io_wr}), 32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_addrs", 32'({mem_addr, io_addr, oam_addr}), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Full copy from page C1 with CPU traffic during the transfer.
    w0 = we_q.size();
    r0 = rd_q.size();
    a0 = act_cnt;
    wr46(8'hC1);
    t = tx_t;
    chk("start_active", 32'(dma_active), 32'd1);
    cpu_acc(1'b1, 16'h1234, 8'h00);
    cpu_acc(1'b1, 16'hC000, 8'h00);
    cpu_acc(1'b0, 16'h8000, 8'h3C);
    cpu_acc(1'b1, 16'hFF80, 8'h00);
    for (int k = 0; k < 15; k++) begin
      a = 16'($urandom);
      if (a == 16'hFF46) a = 16'hFF47;
      if (a[15:8] == 8'hC1) a[15:8] = 8'h12;
      cpu_acc(1'($urandom_range(0, 1)), a, 8'($urandom));
    end
    wait_idle(400);
    chk("c1_we_count", 32'(we_q.size() - w0), OAM_LEN);
    chk("c1_rd_count", 32'(rd_q.size() - r0), OAM_LEN);
    chk("c1_first_rd", 32'(rd_q[r0]), 32'(t + 2));
    chk("c1_last_we", 32'(we_q[we_q.size() - 1]), 32'(t + 162));
    chk("c1_act_cycles", 32'(act_cnt - a0), 32'd162);
    chk_oam(8'hC1);

    // Restart at idx 50 with page D0.
    w0 = we_q.size();
    r0 = rd_q.size();
    wr46(8'hC1);
    t = tx_t;
    while (cyc < t + 52) tick();
    cpu_addr  = 16'hFF46;
    cpu_wdata = 8'hD0;
    cpu_wr    = 1'b1;
    mid();
    chk("rs_rd50", 32'(mem_rd), 32'd1);
    chk("rs_addr50", 32'(mem_addr), 32'hC132);
    tick();
    cpu_wr = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    tx_t = t + 52;
    mid();
    chk("rs_we50", 32'(oam_we), 32'd1);
    chk("rs_oaddr50", 32'(oam_addr), 32'd50);
    chk("rs_odata50", 32'(oam_wdata), 32'(mem[16'hC132]));
    chk("rs_active", 32'(dma_active), 32'd1);
    tick();
    wait_idle(400);
    chk("rs_we_count", 32'(we_q.size() - w0), 32'(51 + OAM_LEN));
    chk("rs_first_new_rd", 32'(rd_q[r0 + 51]), 32'(t + 54));
    chk("rs_last_we", 32'(we_q[we_q.size() - 1]), 32'(t + 214));
    chk_oam(8'hD0);

    // Reset at idx 80.
    wr46(8'hC1);
    t = tx_t;
    while (cyc < t + 82) tick();
    rst = 1'b1;
    tick();
    mid();
    chk("ra_oam_we", 32'(oam_we), 32'd0);
    chk("ra_active", 32'(dma_active), 32'd0);
    w0 = we_q.size();
    tick();
    rst = 1'b0;
    tx_on = 1'b0;
    repeat (5) tick();
    chk("ra_no_we", 32'(we_q.size()), 32'(w0));
    chk("ra_idle", 32'(dma_active), 32'd0);
    cpu_addr = 16'hFF46;
    cpu_rd = 1'b1;
    mid();
    chk("ra_rd46_strobes", 32'({mem_rd, io_rd}), 32'd0);
    tick();
    cpu_rd = 1'b0;
    cpu_addr = '0;
    mid();
    chk("ra_page", 32'(cpu_rdata), 32'd0);
    tick();

    // FF46 write/read are internal only.
    cpu_addr  = 16'hFF46;
    cpu_wdata = 8'h80;
    cpu_wr    = 1'b1;
    tx_t      = cyc;
    tx_on     = 1'b1;
    mid();
    chk("p80_wr_strobes", 32'({mem_rd, mem_wr, io_rd, io_wr}), 32'd0);
    tick();
    cpu_wr = 1'b0;
    cpu_rd = 1'b1;
    mid();
    chk("p80_rd_strobes", 32'({mem_rd, mem_wr, io_rd, io_wr}), 32'd0);
    tick();
    cpu_rd = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    mid();
    chk("p80_page", 32'(cpu_rdata), 32'h80);
    tick();
    wait_idle(400);
    chk_oam(8'h80);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- OAM DMA engine and bus arbiter between the CPU bus and the external memory bus.
- A CPU write to FF46 latches a source page and starts a copy of OAM_LEN bytes from {page,00} to OAM.
- While the copy runs, the engine owns the external bus. CPU accesses to 0000–FEFF are blocked; FF00–FFFF (IO/HRAM) stays reachable.
- Sits between the CPU bus-operation sequencer and the memory/IO decode. One clk equals one M-cycle.

Parameters:
- OAM_LEN, 160, number of bytes copied (max 256).
- START_DELAY, 1, cycles between the FF46 write and the first DMA read (min 1).

Ports:
- clk  in  1  M-cycle clock
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  16  CPU access address
- cpu_wdata  in  8  CPU write data
- cpu_rd  in  1  CPU read strobe, one cycle
- cpu_wr  in  1  CPU write strobe, one cycle
- cpu_rdata  out  8  read data, valid the cycle after cpu_rd
- mem_addr  out  16  external bus address (0000–FEFF space)
- mem_wdata  out  8  external bus write data
- mem_rd  out  1  external read strobe
- mem_wr  out  1  external write strobe
- mem_rdata  in  8  external read data, valid the cycle after mem_rd
- io_addr  out  8  low byte for FF00–FFFF accesses
- io_wdata  out  8  IO/HRAM write data
- io_rd  out  1  IO/HRAM read strobe
- io_wr  out  1  IO/HRAM write strobe
- io_rdata  in  8  IO/HRAM read data, valid the cycle after io_rd
- oam_addr  out  8  OAM byte index
- oam_wdata  out  8  OAM write data
- oam_we  out  1  OAM write enable
- dma_active  out  1  high in START, ACTIVE and DRAIN

Behaviour:
- Reset (sync): state IDLE, src_page = 8'h00, idx = 0, rd_pend = 0.
  - All strobes 0, dma_active 0, cpu_rdata 8'h00, mem_addr 0, io_addr 0, oam_addr 0.
- Address routing (combinational, every cycle):
  - cpu_addr == FF46: handled internally, never forwarded.
  - cpu_addr >= FF00: forwarded to io_*, in every state.
  - cpu_addr < FF00: forwarded to mem_* only when the state is IDLE or START.
  - In ACTIVE/DRAIN, CPU accesses below FF00 are blocked: writes dropped, reads return 8'hFF.
- FF46 write: src_page <= cpu_wdata, idx <= 0, delay counter <= START_DELAY-1, state <= START.
  - Accepted in any state, so a write during ACTIVE/DRAIN restarts the transfer.
- FF46 read: returns src_page.
- cpu_rdata: a registered read-source tag (MEM/IO/REG/BLOCKED) is captured with cpu_rd. The next cycle muxes mem_rdata, io_rdata, src_page or 8'hFF.
- FSM:
  - IDLE: waits for an FF46 write.
  - START: delay counter decrements; at 0, go to ACTIVE.
  - ACTIVE: mem_rd = 1, mem_addr = {src_page, idx}, rd_pend <= 1, idx++. When idx == OAM_LEN-1 is issued, go to DRAIN.
  - DRAIN: one cycle for the final OAM write, then IDLE.
- OAM write pipeline: when rd_pend is set, oam_we = 1, oam_addr = idx_prev, oam_wdata = mem_rdata.
  - rd_pend clears in any cycle without a DMA read.
- Timing with START_DELAY = 1 and FF46 written in cycle T:
  - START in T+1.
  - Reads in T+2..T+161.
  - OAM writes in T+3..T+162.
  - dma_active high T+1..T+162.
- Restart mid-transfer: the in-flight rd_pend OAM write still completes in the next cycle, even though the state is now START. The new transfer then begins at idx 0.
- Source page is issued as-is; there is no special handling for pages >= FE.
- The idx counter is 8-bit and never wraps past OAM_LEN-1.
- Reset mid-transfer: aborts immediately, with no further OAM writes.

Test Plan:
- Write FF46 = 8'hC1; preload C100+i with i^8'h5A -> exactly 160 oam_we pulses, OAM[i] = i^8'h5A, first read at T+2, last write at T+162, dma_active high 162 cycles.
- During DMA, CPU reads C000 and writes 8000 -> cpu_rdata = 8'hFF, no CPU mem_wr. CPU read FF80 -> io_rd = 1, io_addr = 8'h80, cpu_rdata = io_rdata.
- CPU read at 1234 in the START cycle -> forwarded on mem_* and returns mem_rdata; the DMA read begins the next cycle.
- At idx = 50, rewrite FF46 = 8'hD0 -> OAM[50] still written from page C1, then idx restarts at 0 from D000, with 160 further writes.
- Assert rst at idx = 80 -> next cycle oam_we = 0, dma_active = 0, state IDLE, FF46 reads 8'h00.
- Write FF46 = 8'h80 then read FF46 -> 8'h80, with no io_* or mem_* strobe for either access.
